// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for the cache controller.
// master = CPU requester plus memory responder; slave = the controller itself.
interface cache_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_valid;
  logic              cpu_rw;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;

  logic              mem_valid;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [127:0]      mem_wdata;
  logic [127:0]      mem_rdata;
  logic              mem_ready;

  modport master (
    output cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  mem_valid, mem_rw, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

  modport slave (
    input  cpu_valid, cpu_rw, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output mem_valid, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Direct-mapped, write-back, write-allocate cache controller, 128-bit lines,
// one outstanding line request to memory at a time.
//
// state      | meaning
// IDLE       | waiting for cpu_valid; latch the request on acceptance
// COMPARE    | tag check of latched index; hit completes, miss starts memory traffic
// WRITE_BACK | dirty victim line being written to memory
// ALLOCATE   | fill line being read from memory, then re-compare
module cache_ctrl_fsm #(
  parameter int INDEX_W = 10,
  parameter int ADDR_W  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);
  localparam int TAG_W = ADDR_W - INDEX_W - 4;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  // Byte-offset bits [1:0] are never used, so only the word address is held.
  logic              req_rw_q;
  logic [ADDR_W-3:0] req_addr_q;
  logic [31:0]       req_wdata_q;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_word;

  assign req_tag  = req_addr_q[ADDR_W-3:INDEX_W+2];
  assign req_idx  = req_addr_q[INDEX_W+1:2];
  assign req_word = req_addr_q[1:0];

  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  logic [TAG_W-1:0] stored_tag;
  logic [127:0]     stored_line;
  logic [127:0]     line_wr;
  logic             hit;

  assign stored_tag  = tag_mem[req_idx];
  assign stored_line = data_mem[req_idx];
  assign hit         = valid_q[req_idx] && (stored_tag == req_tag);

  always_comb begin
    line_wr = stored_line;
    line_wr[{req_word, 5'b0} +: 32] = req_wdata_q;
  end

  logic              mem_valid_q, mem_valid_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [127:0]      mem_wdata_q, mem_wdata_d;

  logic        cpu_ready_c;
  logic [31:0] cpu_rdata_c;
  logic        accept, hit_write, fill;

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_c = 1'b0;
    cpu_rdata_c = '0;
    accept      = 1'b0;
    hit_write   = 1'b0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_valid) begin
          accept  = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready_c = 1'b1;
          if (req_rw_q) hit_write = 1'b1;
          else          cpu_rdata_c = stored_line[{req_word, 5'b0} +: 32];
          state_d = IDLE;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = {stored_tag, req_idx, 4'b0};
          mem_wdata_d = stored_line;
          state_d     = WRITE_BACK;
        end else begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b0;
          mem_addr_d  = {req_tag, req_idx, 4'b0};
          mem_wdata_d = '0;
          state_d     = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        // mem_valid stays high straight into the fill request.
        if (bus.mem_ready) begin
          mem_rw_d    = 1'b0;
          mem_addr_d  = {req_tag, req_idx, 4'b0};
          mem_wdata_d = '0;
          state_d     = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (bus.mem_ready) begin
          fill        = 1'b1;
          mem_valid_d = 1'b0;
          state_d     = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (accept) begin
        req_rw_q    <= bus.cpu_rw;
        req_addr_q  <= bus.cpu_addr[ADDR_W-1:2];
        req_wdata_q <= bus.cpu_wdata;
      end
      if (fill) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end else if (hit_write) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Tag and data contents need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[req_idx] <= bus.mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end else if (hit_write) begin
      data_mem[req_idx] <= line_wr;
    end
  end

  assign bus.cpu_ready = cpu_ready_c;
  assign bus.cpu_rdata = cpu_rdata_c;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Randomized bench for cache_ctrl_fsm: a transaction-level cache/memory model
// predicts the memory traffic, read data and completion latency of each access.
module tb_cache_ctrl_fsm;
  localparam int INDEX_W = 10;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = ADDR_W - INDEX_W - 4;
  localparam int LINES   = 1 << INDEX_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  cache_ctrl_fsm #(.INDEX_W(INDEX_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Backing memory: lines never written return an address-derived pattern.
  logic [127:0] mem_model [int];

  function automatic logic [127:0] mem_line(input int la);
    logic [31:0] a;
    a = la;
    if (mem_model.exists(la)) return mem_model[la];
    return {a * 32'h9E37_79B1, ~a, a ^ 32'h5A5A_5A5A, a + 32'h0123_4567};
  endfunction

  typedef struct {
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wdata;
    int           lat;
  } op_t;

  op_t mem_log[$];
  int  force_lat = -1;
  bit  busy = 1'b0;
  int  wait_left = 0;
  op_t snap;
  bit  in_access = 1'b0;

  // Memory responder: random latency, stability of held requests, stray mem_ready while idle.
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    if (!rst_n) begin
      busy = 1'b0;
    end else if (bus.mem_valid) begin
      if (!busy) begin
        busy       = 1'b1;
        snap.rw    = bus.mem_rw;
        snap.addr  = bus.mem_addr;
        snap.wdata = bus.mem_wdata;
        snap.lat   = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
        wait_left  = snap.lat;
      end else begin
        check("mem_rw_hold", 128'(bus.mem_rw), 128'(snap.rw));
        check("mem_addr_hold", 128'(bus.mem_addr), 128'(snap.addr));
        check("mem_wdata_hold", bus.mem_wdata, snap.wdata);
      end
      if (wait_left == 0) begin
        bus.mem_ready = 1'b1;
        if (snap.rw) mem_model[int'(snap.addr >> 4)] = snap.wdata;
        else         bus.mem_rdata = mem_line(int'(snap.addr >> 4));
        mem_log.push_back(snap);
        busy = 1'b0;
      end else begin
        wait_left--;
      end
    end else begin
      busy = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (!in_access) check("ready_outside_access", 128'(bus.cpu_ready), 128'd0);
      if (!bus.mem_rw) check("wdata_zero_on_read", bus.mem_wdata, 128'd0);
      check("mem_addr_aligned", 128'(bus.mem_addr[3:0]), 128'd0);
    end
  end

  bit               m_valid [LINES];
  bit               m_dirty [LINES];
  logic [TAG_W-1:0] m_tag   [LINES];
  logic [127:0]     m_data  [LINES];

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic do_access(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         word;
    logic [127:0]       line;
    logic [31:0]        exp_rdata;
    op_t                exp_ops[$];
    op_t                o;
    bit                 hit, seen;
    int                 k, exp_k;
    idx  = addr[INDEX_W+3:4];
    tag  = addr[ADDR_W-1:INDEX_W+4];
    word = addr[3:2];
    hit  = m_valid[idx] && (m_tag[idx] == tag);
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        o.rw = 1'b1; o.addr = {m_tag[idx], idx, 4'b0}; o.wdata = m_data[idx]; o.lat = 0;
        exp_ops.push_back(o);
      end
      o.rw = 1'b0; o.addr = {tag, idx, 4'b0}; o.wdata = '0; o.lat = 0;
      exp_ops.push_back(o);
    end

    @(negedge clk);
    in_access = 1'b1;
    mem_log.delete();
    bus.cpu_valid = 1'b1;
    bus.cpu_rw    = rw;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    bus.cpu_rw    = 1'($urandom);
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;
    k = 1;
    seen = 1'b0;
    rdata = 'x;
    while (k < 200) begin
      if (bus.cpu_ready) begin
        seen  = 1'b1;
        rdata = bus.cpu_rdata;
        break;
      end
      @(negedge clk);
      k++;
    end
    check("ready_seen", 128'(seen), 128'd1);

    if (!hit) begin
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_data[idx]  = mem_line(int'({tag, idx}));
    end
    line = m_data[idx];
    if (rw) begin
      line[word*32 +: 32] = wdata;
      m_data[idx]  = line;
      m_dirty[idx] = 1'b1;
      exp_rdata    = '0;
    end else begin
      exp_rdata = line[word*32 +: 32];
    end
    check("cpu_rdata", 128'(rdata), 128'(exp_rdata));

    exp_k = 1 + (exp_ops.size() > 0 ? 1 : 0);
    foreach (mem_log[i]) exp_k += mem_log[i].lat + 1;
    check("ready_latency", 128'(k), 128'(exp_k));
    check("mem_op_count", 128'(mem_log.size()), 128'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < mem_log.size(); i++) begin
      check("mem_op_rw", 128'(mem_log[i].rw), 128'(exp_ops[i].rw));
      check("mem_op_addr", 128'(mem_log[i].addr), 128'(exp_ops[i].addr));
      check("mem_op_wdata", mem_log[i].wdata, exp_ops[i].wdata);
    end

    @(negedge clk);
    check("ready_single_pulse", 128'(bus.cpu_ready), 128'd0);
    in_access = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] a;

  initial begin
    bus.cpu_valid = 1'b0;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_cpu_ready", 128'(bus.cpu_ready), 128'd0);
    check("rst_cpu_rdata", 128'(bus.cpu_rdata), 128'd0);
    check("rst_mem_valid", 128'(bus.mem_valid), 128'd0);
    check("rst_mem_rw", 128'(bus.mem_rw), 128'd0);
    check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    check("rst_mem_wdata", bus.mem_wdata, 128'd0);
    rst_n = 1'b1;

    // Cold read miss with a hand-built fill line.
    mem_model[32'h123] = 128'hDDDD_CCCC_BBBB_AAAA_1111_2222_5555_6666;
    do_access(1'b0, 32'h0000_1234, 32'h0, rd);
    check("cold_rdata", 128'(rd), 128'h1111_2222);
    check("cold_ops", 128'(mem_log.size()), 128'd1);
    if (mem_log.size() > 0) begin
      check("cold_addr", 128'(mem_log[0].addr), 128'h1230);
      check("cold_rw", 128'(mem_log[0].rw), 128'd0);
    end

    do_access(1'b0, 32'h0000_1234, 32'h0, rd);
    check("hit_rdata", 128'(rd), 128'h1111_2222);
    check("hit_no_mem", 128'(mem_log.size()), 128'd0);

    // Write hit then dirty eviction by an aliasing read.
    do_access(1'b1, 32'h0000_1238, 32'hCAFE_F00D, rd);
    do_access(1'b0, 32'h0001_1230, 32'h0, rd);
    check("evict_ops", 128'(mem_log.size()), 128'd2);
    if (mem_log.size() == 2) begin
      check("evict_wb_rw", 128'(mem_log[0].rw), 128'd1);
      check("evict_wb_addr", 128'(mem_log[0].addr), 128'h1230);
      check("evict_wb_word2", 128'(mem_log[0].wdata[95:64]), 128'hCAFE_F00D);
      check("evict_wb_word1", 128'(mem_log[0].wdata[63:32]), 128'h1111_2222);
      check("evict_fill_addr", 128'(mem_log[1].addr), 128'h0001_1230);
    end

    // Clean eviction: only a fill.
    do_access(1'b0, 32'h0000_2000, 32'h0, rd);
    do_access(1'b0, 32'h0004_2000, 32'h0, rd);
    check("clean_ops", 128'(mem_log.size()), 128'd1);
    if (mem_log.size() > 0) check("clean_rw", 128'(mem_log[0].rw), 128'd0);

    // Long stall, then a same-cycle memory completion.
    force_lat = 20;
    do_access(1'b0, 32'h0000_3000, 32'h0, rd);
    force_lat = 0;
    do_access(1'b0, 32'h0008_3000, 32'h0, rd);
    do_access(1'b1, 32'h0008_3004, 32'h1234_5678, rd);
    do_access(1'b0, 32'h0000_3000, 32'h0, rd);

    // Reset in the middle of a fill.
    force_lat = 50;
    @(negedge clk);
    bus.cpu_valid = 1'b1;
    bus.cpu_rw    = 1'b0;
    bus.cpu_addr  = 32'h0000_4440;
    @(negedge clk);
    bus.cpu_valid = 1'b0;
    for (int i = 0; i < 10 && !bus.mem_valid; i++) @(negedge clk);
    check("midfill_req_started", 128'(bus.mem_valid), 128'd1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midfill_mem_valid_async", 128'(bus.mem_valid), 128'd0);
    check("midfill_cpu_ready", 128'(bus.cpu_ready), 128'd0);
    check("midfill_mem_addr", 128'(bus.mem_addr), 128'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    force_lat = -1;
    repeat (5) @(negedge clk);
    do_access(1'b0, 32'h0000_4440, 32'h0, rd);
    check("post_reset_miss", 128'(mem_log.size()), 128'd1);
    do_access(1'b0, 32'h0000_1234, 32'h0, rd);
    check("post_reset_old_line_miss", 128'(mem_log.size()), 128'd1);

    // Random traffic over a few aliasing tags and indexes.
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) << (INDEX_W + 4)) | ($urandom_range(0, 3) << 4) | ($urandom & 32'hF);
      do_access(1'($urandom), a, $urandom, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
- Direct-mapped, write-back, write-allocate cache controller for the 128-bit-line cache datapath.
- Sits between one CPU requester and the line-granular memory controller.
- Holds its own tag array (valid, dirty, tag per line) and data array.
- Sequences every access through compare, write-back and allocate, using one outstanding memory request at a time.

Parameters:
- INDEX_W, 10, index width; the cache holds 2^INDEX_W lines.
- ADDR_W, 32, CPU byte-address width.
- TAG_W, ADDR_W-INDEX_W-4, tag width (derived; 18 at the defaults).

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- cpu_valid, in, 1, CPU request present; sampled only in IDLE.
- cpu_rw, in, 1, 0 = read, 1 = write.
- cpu_addr, in, ADDR_W, byte address; tag=[ADDR_W-1:INDEX_W+4], index=[INDEX_W+3:4], word=[3:2], [1:0] ignored.
- cpu_wdata, in, 32, write data.
- cpu_rdata, out, 32, read data; valid while cpu_ready=1.
- cpu_ready, out, 1, one-cycle completion pulse.
- mem_valid, out, 1, memory request valid.
- mem_rw, out, 1, 0 = line read, 1 = line write.
- mem_addr, out, ADDR_W, line-aligned byte address; [3:0]=0.
- mem_wdata, out, 128, write-back line.
- mem_rdata, in, 128, fill line; valid when mem_ready=1.
- mem_ready, in, 1, memory completion pulse; ignored while mem_valid=0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; cpu_ready, cpu_rdata, mem_valid, mem_rw, mem_addr, mem_wdata all 0; every valid and dirty bit cleared. Tag and data contents are don't-care.
- Reset mid-operation: any in-flight memory request is abandoned immediately and mem_valid falls with rst_n. The latched CPU request is lost and never acknowledged.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE, encoded in 2 bits.
- IDLE:
  - cpu_valid=1 latches cpu_rw, cpu_addr and cpu_wdata, then moves to COMPARE.
  - The CPU may drop or change its inputs after the accept edge.
- COMPARE: tag/data read of the latched index is combinational. hit = valid && stored tag == latched tag.
  - Read hit: cpu_rdata = line word[latched word]; cpu_ready=1 for this cycle; next state IDLE.
  - Write hit: replace the selected 32-bit word (other words untouched); set valid=1 and dirty=1; cpu_ready=1; cpu_rdata=0; next state IDLE.
  - Miss with valid && dirty: next state WRITE_BACK. Register mem_valid=1, mem_rw=1, mem_addr={stored tag, index, 4'b0}, mem_wdata=stored line.
  - Miss otherwise: next state ALLOCATE. Register mem_valid=1, mem_rw=0, mem_addr={latched tag, index, 4'b0}.
- WRITE_BACK:
  - Hold mem_valid, mem_addr and mem_wdata stable until mem_ready=1.
  - On that edge, set mem_rw=0 and mem_addr={latched tag, index, 0}, keep mem_valid=1, and go to ALLOCATE.
  - mem_valid stays high across the write-back-to-fill handoff.
- ALLOCATE:
  - Hold the request until mem_ready=1.
  - On that edge, write mem_rdata into the data array, set tag=latched tag, valid=1, dirty=0, drop mem_valid, and go to COMPARE.
  - The re-compare then hits and completes the original read or write.
- Latency:
  - Hit: cpu_ready 1 cycle after the accept edge (2 cycles from cpu_valid sampled to ready).
  - Clean miss: 2 cycles + memory latency.
  - Dirty miss: 2 cycles + two memory latencies.
- mem_ready arriving in the same cycle mem_valid first rises is legal and is taken as completion.
- mem_wdata is 0 whenever mem_rw=0.
- cpu_valid held high through an access starts the next access only after returning to IDLE. Back-to-back throughput is therefore one access per 2 cycles on hits.
- cpu_ready is never high for more than 1 cycle per accepted request; it is 0 in every state except COMPARE-hit.

Test Plan:
- Cold read miss: after reset, read 0x0000_1234. Expect mem read, mem_addr=0x0000_1230. Return line 0xDDDD_CCCC_BBBB_AAAA_… with word1=0x1111_2222. Expect cpu_ready with cpu_rdata=0x1111_2222, exactly 1 mem request.
- Read hit: repeat the same read. Expect no mem_valid; cpu_ready 2 cycles after cpu_valid with the same data.
- Write hit, then dirty eviction:
  - Write 0xCAFE_F00D to 0x0000_1238.
  - Read 0x0001_1230 (same index, different tag).
  - Expect a mem write to 0x0000_1230 whose word2=0xCAFE_F00D, followed by a mem read of 0x0001_1230.
- Clean eviction: read two aliasing addresses with no write in between. Expect no mem write, only fills.
- Memory stall: hold mem_ready low for 20 cycles during ALLOCATE. Expect mem_valid, mem_addr and mem_rw stable throughout and cpu_ready low until completion. Repeat with mem_ready high in the first request cycle.
- Reset mid-fill: assert rst_n low during ALLOCATE. Expect mem_valid=0 asynchronously, state IDLE, no cpu_ready. A subsequent read of the same address misses again.
